// File: rtl/rom_word_loader_pkg.sv
// Program-memory word format shared by the ROM loader and the nibble-packed MAC compute top.
// Operand nibbles a..h occupy word bits [3:0]..[31:28].
package rom_word_loader_pkg;
    localparam int NIB_W         = 4;
    localparam int NIBS_PER_WORD = 8;
    localparam int WORD_W        = NIB_W * NIBS_PER_WORD;
    localparam int ADDR_W        = 4;
    localparam int ADDR_STEP     = 4;
    localparam int NUM_WORDS     = 4;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;
endpackage

// File: rtl/rom_word_loader_if.sv
// Nibble stream in, program-memory write port out.
// The loader uses the slave modport; the nibble source and memory use master.
interface rom_word_loader_if;
    import rom_word_loader_pkg::*;

    logic              in_valid;
    logic [NIB_W-1:0]  in_nib;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output in_valid, in_nib,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_nib,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rom_word_loader_nibble_packer.sv
// Inserts accepted nibbles into a word at position nib_cnt; word_full flags the last one.
// word is the packing register with the current nibble already inserted.
module rom_word_loader_nibble_packer #(
    parameter int NIB_W         = 4,
    parameter int NIBS_PER_WORD = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           accept,
    input  logic [NIB_W-1:0]               nib,
    output logic [NIB_W*NIBS_PER_WORD-1:0] word,
    output logic                           word_full
);
    import rom_word_loader_pkg::*;

    localparam int CNT_W = (NIBS_PER_WORD > 1) ? $clog2(NIBS_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS_PER_WORD - 1);

    logic [NIB_W*NIBS_PER_WORD-1:0] pack_q;
    logic [CNT_W-1:0]               nib_cnt;

    always_comb begin
        word = pack_q;
        for (int k = 0; k < NIBS_PER_WORD; k++) begin
            if (nib_cnt == CNT_W'(k)) begin
                word[k*NIB_W +: NIB_W] = nib;
            end
        end
    end

    assign word_full = accept && (nib_cnt == LAST_NIB);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pack_q  <= '0;
            nib_cnt <= '0;
        end else if (accept) begin
            if (word_full) begin
                pack_q  <= '0;
                nib_cnt <= '0;
            end else begin
                pack_q  <= word;
                nib_cnt <= nib_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/rom_word_loader.sv
// Packs the nibble stream into 32-bit program words and writes NUM_WORDS of them
// at byte-stepped addresses, then holds done so the compute block can leave reset.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FILL  | accepting nibbles of the current word
//   WRITE | one-cycle memory write of the packed word
//   DONE  | all words written, waiting for a reload start
module rom_word_loader #(
    parameter int NIB_W         = rom_word_loader_pkg::NIB_W,
    parameter int NIBS_PER_WORD = rom_word_loader_pkg::NIBS_PER_WORD,
    parameter int ADDR_W        = rom_word_loader_pkg::ADDR_W,
    parameter int ADDR_STEP     = rom_word_loader_pkg::ADDR_STEP,
    parameter int NUM_WORDS     = rom_word_loader_pkg::NUM_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    rom_word_loader_if.slave bus,
    output logic             busy,
    output logic             done
);
    import rom_word_loader_pkg::*;

    localparam int DATA_W = NIB_W * NIBS_PER_WORD;
    localparam int WC_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    localparam logic [1:0] S_IDLE  = 2'(LD_IDLE);
    localparam logic [1:0] S_FILL  = 2'(LD_FILL);
    localparam logic [1:0] S_WRITE = 2'(LD_WRITE);
    localparam logic [1:0] S_DONE  = 2'(LD_DONE);

    if (NUM_WORDS * ADDR_STEP > 2**ADDR_W) begin : g_addr_range_check
        $error("rom_word_loader: NUM_WORDS*ADDR_STEP exceeds the address space");
    end
    if (DATA_W != WORD_W || ADDR_W != rom_word_loader_pkg::ADDR_W) begin : g_format_check
        $error("rom_word_loader: parameters disagree with the program-memory format");
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [WC_W-1:0]   word_cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              in_ready;
    logic              accept;
    logic              load_start;
    logic              packer_clear;
    logic [DATA_W-1:0] word_next;
    logic              word_full;

    assign in_ready     = (state == S_FILL);
    assign accept       = bus.in_valid && in_ready;
    assign load_start   = start && (state == S_IDLE || state == S_DONE);
    assign packer_clear = load_start || (state == S_WRITE);

    rom_word_loader_nibble_packer #(
        .NIB_W         (NIB_W),
        .NIBS_PER_WORD (NIBS_PER_WORD)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (packer_clear),
        .accept    (accept),
        .nib       (bus.in_nib),
        .word      (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            word_cnt  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_FILL;
                        addr     <= '0;
                        word_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (word_full) begin
                        state     <= S_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr;
                        wr_data_q <= word_next;
                    end
                end
                S_WRITE: begin
                    addr     <= addr + STEP;
                    word_cnt <= word_cnt + WC_W'(1);
                    state    <= (word_cnt == LAST_WORD) ? S_DONE : S_FILL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // wr_addr keeps the last written address through DONE; addr already points past it
    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state == S_FILL) || (state == S_WRITE);
    assign done         = (state == S_DONE);
endmodule

// File: tb/tb_rom_word_loader.sv
// Directed bench for rom_word_loader: one task per scenario, expected words hand-computed.
`timescale 1ns/1ps
module tb_rom_word_loader;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    rom_word_loader_if bus();

    rom_word_loader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [3:0]  stim [64];
    int          n_wr;
    int          rdy_bad;
    logic [3:0]  log_addr [16];
    logic [31:0] log_data [16];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (n_wr < 16) begin
                log_addr[n_wr] = bus.wr_addr;
                log_data[n_wr] = bus.wr_data;
            end
            n_wr++;
            if (bus.in_ready !== 1'b0) rdy_bad++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Source holds each nibble until accepted; start pulses on cycle indices s0/s1.
    task automatic feed(input int n, input bit toggle, input int s0, input int s1,
                        output int cycles);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 400) begin
            bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.in_nib   = stim[idx];
            start        = (cyc == s0 || cyc == s1);
            @(negedge clk);
            acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        n_total++;
        if (idx != n) $display("FAIL feed_accepted: got %0d want %0d", idx, n);
        else n_pass++;
        cycles = cyc;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL %s_done: got %b want 1", tag, done);
        else n_pass++;
    endtask

    task automatic check_counting_log(input string tag);
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h76543210; exp_d[1] = 32'hFEDCBA98;
        exp_d[2] = 32'h76543210; exp_d[3] = 32'hFEDCBA98;
        n_total++;
        if (n_wr != 4) $display("FAIL %s_write_count: got %0d want 4", tag, n_wr);
        else n_pass++;
        n_total++;
        if (rdy_bad != 0) $display("FAIL %s_ready_in_write: got %0d want 0", tag, rdy_bad);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_addr[i] !== 4'(4*i) || log_data[i] !== exp_d[i])
                $display("FAIL %s_write%0d: got %h@%0d want %h@%0d",
                         tag, i, log_data[i], log_addr[i], exp_d[i], 4*i);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_nib = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); else n_pass++;
        n_total++; if (bus.wr_addr !== 4'h0) $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr); else n_pass++;
        n_total++; if (bus.wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_idle_stall();
        n_wr = 0;
        bus.in_valid = 1'b1;
        bus.in_nib   = 4'h5;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL idle_in_ready: cycle %0d got %b want 0", c, bus.in_ready);
            else n_pass++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_total++; if (n_wr != 0) $display("FAIL idle_writes: got %0d want 0", n_wr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        int cyc;
        n_wr = 0; rdy_bad = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'(i);
        pulse_start();
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_fill: got %b want 1", busy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready_fill: got %b want 1", bus.in_ready); else n_pass++;
        feed(32, 1'b0, -1, -1, cyc);
        n_total++; if (cyc != 35) $display("FAIL basic_cycles: got %0d want 35", cyc); else n_pass++;
        n_total++; if (bus.wr_en !== 1'b1) $display("FAIL basic_last_wr_en: got %b want 1", bus.wr_en); else n_pass++;
        n_total++; if (bus.wr_addr !== 4'd12) $display("FAIL basic_last_addr: got %0d want 12", bus.wr_addr); else n_pass++;
        n_total++; if (bus.wr_data !== 32'hFEDCBA98) $display("FAIL basic_last_data: got %h want fedcba98", bus.wr_data); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL basic_done_early: got %b want 0", done); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b want 0", busy); else n_pass++;
        n_total++; if (bus.wr_en !== 1'b0) $display("FAIL basic_wr_en_done: got %b want 0", bus.wr_en); else n_pass++;
        n_total++; if (bus.wr_addr !== 4'd12) $display("FAIL basic_addr_hold: got %0d want 12", bus.wr_addr); else n_pass++;
        check_counting_log("basic");
    endtask

    task automatic test_backpressure();
        int cyc;
        n_wr = 0; rdy_bad = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'(i);
        pulse_start();
        n_total++; if (done !== 1'b0) $display("FAIL bp_done_drop: got %b want 0", done); else n_pass++;
        feed(32, 1'b1, -1, -1, cyc);
        wait_done("bp");
        check_counting_log("bp");
    endtask

    task automatic test_reload();
        int cyc;
        n_wr = 0; rdy_bad = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'hA;
        pulse_start();
        n_total++; if (done !== 1'b0) $display("FAIL reload_done_drop: got %b want 0", done); else n_pass++;
        feed(32, 1'b0, -1, -1, cyc);
        wait_done("reload");
        n_total++; if (n_wr != 4) $display("FAIL reload_write_count: got %0d want 4", n_wr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_addr[i] !== 4'(4*i) || log_data[i] !== 32'hAAAAAAAA)
                $display("FAIL reload_write%0d: got %h@%0d want aaaaaaaa@%0d", i, log_data[i], log_addr[i], 4*i);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        n_wr = 0; rdy_bad = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'(i);
        pulse_start();
        feed(32, 1'b0, 5, 8, cyc);
        n_total++; if (cyc != 35) $display("FAIL startign_cycles: got %0d want 35", cyc); else n_pass++;
        wait_done("startign");
        check_counting_log("startign");
    endtask

    task automatic test_reset_mid();
        int cyc;
        n_wr = 0; rdy_bad = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'(i);
        pulse_start();
        feed(13, 1'b0, -1, -1, cyc);
        rst = 1'b1; start = 1'b1; bus.in_valid = 1'b1; bus.in_nib = 4'h3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        n_total++; if (bus.wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %b want 0", bus.wr_en); else n_pass++;
        n_total++; if (bus.wr_addr !== 4'h0) $display("FAIL midrst_wr_addr: got %h want 0", bus.wr_addr); else n_pass++;
        n_total++; if (bus.wr_data !== 32'h0) $display("FAIL midrst_wr_data: got %h want 0", bus.wr_data); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (n_wr != 1) $display("FAIL midrst_partial_write: got %0d writes want 1", n_wr); else n_pass++;
        n_wr = 0;
        for (int i = 0; i < 32; i++) stim[i] = 4'h1;
        pulse_start();
        feed(32, 1'b0, -1, -1, cyc);
        wait_done("midrst");
        n_total++; if (n_wr != 4) $display("FAIL midrst_write_count: got %0d want 4", n_wr); else n_pass++;
        n_total++;
        if (log_addr[0] !== 4'h0 || log_data[0] !== 32'h11111111)
            $display("FAIL midrst_first_write: got %h@%0d want 11111111@0", log_data[0], log_addr[0]);
        else n_pass++;
        n_total++;
        if (log_addr[3] !== 4'd12 || log_data[3] !== 32'h11111111)
            $display("FAIL midrst_last_write: got %h@%0d want 11111111@12", log_data[3], log_addr[3]);
        else n_pass++;
    endtask

    initial begin
        n_wr = 0;
        rdy_bad = 0;
        test_reset();
        test_idle_stall();
        test_basic();
        test_backpressure();
        test_reload();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
